// File: rtl/sid_seq_pkg.sv
// Shared op codes, FSM states and WRITE-argument layout for the SID register sequencer.
package sid_seq_pkg;

  localparam int unsigned OP_W      = 2;
  localparam int unsigned VOICE_LSB = 11;
  localparam int unsigned ADDR_LSB  = 8;
  localparam int unsigned VOICE_W   = 2;
  localparam int unsigned ADDR_W    = 3;
  localparam int unsigned DATA_W    = 8;
  localparam int unsigned CNT_W     = 16;

  localparam logic [OP_W-1:0] OP_WRITE = 2'b00;
  localparam logic [OP_W-1:0] OP_WAIT  = 2'b01;
  localparam logic [OP_W-1:0] OP_SYNC  = 2'b10;
  localparam logic [OP_W-1:0] OP_RSVD  = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_STROBE,
    ST_HOLD,
    ST_WAIT,
    ST_SYNC
  } state_e;

  // Register-write payload presented on the SID parallel port.
  typedef struct packed {
    logic [VOICE_W-1:0] voice;
    logic [ADDR_W-1:0]  addr;
    logic [DATA_W-1:0]  data;
  } bus_word_t;

  function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                       input int unsigned c);
    int unsigned m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/sid_seq_fifo.sv
// Synchronous command FIFO with flush; pushes while full and pops while empty are dropped.
module sid_seq_fifo #(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned WIDTH = 26,
  localparam int unsigned LVL_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  input  logic             flush,
  output logic [WIDTH-1:0] head_c,
  output logic             empty,
  output logic             not_full,
  output logic [LVL_W-1:0] level,
  output logic [LVL_W-1:0] level_nxt_c
);

  localparam int unsigned PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             push_ok;
  logic             pop_ok;

  // Accepted transfers; flush overrides both.
  always_comb begin
    push_ok     = push && not_full && !flush;
    pop_ok      = pop && !empty && !flush;
    level_nxt_c = flush ? '0 : (level + LVL_W'(push_ok) - LVL_W'(pop_ok));
    head_c      = mem[rd_ptr];
  end

  // Pointers, occupancy and registered status flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      level    <= '0;
      empty    <= 1'b1;
      not_full <= 1'b1;
    end else begin
      if (flush) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
      end else begin
        if (push_ok) wr_ptr <= wr_ptr + PTR_W'(1);
        if (pop_ok)  rd_ptr <= rd_ptr + PTR_W'(1);
      end
      level    <= level_nxt_c;
      empty    <= (level_nxt_c == '0);
      not_full <= (level_nxt_c < LVL_W'(DEPTH));
    end
  end

  // Entry storage; no reset needed since reads are gated by occupancy.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/sid_reg_sequencer.sv
// SID write-port sequencer: plays queued WRITE/WAIT/SYNC commands with programmable bus timing.
module sid_reg_sequencer
  import sid_seq_pkg::*;
#(
  parameter int unsigned DEPTH      = 16,
  parameter int unsigned WAIT_W     = 24,
  parameter int unsigned SETUP_CYC  = 1,
  parameter int unsigned STROBE_CYC = 2,
  parameter int unsigned HOLD_CYC   = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic [OP_W-1:0]         cmd_op,
  input  logic [WAIT_W-1:0]       cmd_arg,
  input  logic                    sync_in,
  input  logic                    flush,
  output logic [ADDR_W-1:0]       bus_addr,
  output logic [VOICE_W-1:0]      bus_voice,
  output logic [DATA_W-1:0]       bus_data,
  output logic                    bus_we,
  output logic                    busy,
  output logic [$clog2(DEPTH):0]  level,
  output logic                    err_op,
  output logic [CNT_W-1:0]        writes_done
);

  localparam int unsigned ARG_W = WAIT_W;
  localparam int unsigned CMD_W = OP_W + ARG_W;
  localparam int unsigned LVL_W = $clog2(DEPTH) + 1;
  localparam int unsigned PH_W  = $clog2(max3(SETUP_CYC, STROBE_CYC, HOLD_CYC) + 1);

  state_e            state_q, state_d;
  logic [PH_W-1:0]   ph_q, ph_d;
  logic [WAIT_W-1:0] wcnt_q, wcnt_d;
  bus_word_t         bus_q, bus_d;
  logic              err_d;
  logic [CNT_W-1:0]  wd_d;
  logic              pop_c;
  logic              fifo_empty;
  logic [CMD_W-1:0]  head_c;
  logic [LVL_W-1:0]  level_nxt_c;
  logic [OP_W-1:0]   head_op;
  logic [ARG_W-1:0]  head_arg;

  assign head_op     = head_c[CMD_W-1 -: OP_W];
  assign head_arg    = head_c[ARG_W-1:0];
  assign bus_addr    = bus_q.addr;
  assign bus_voice   = bus_q.voice;
  assign bus_data    = bus_q.data;

  sid_seq_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (CMD_W)
  ) u_fifo (
    .clk         (clk),
    .rst         (rst),
    .push        (cmd_valid),
    .push_data   ({cmd_op, cmd_arg}),
    .pop         (pop_c),
    .flush       (flush),
    .head_c      (head_c),
    .empty       (fifo_empty),
    .not_full    (cmd_ready),
    .level       (level),
    .level_nxt_c (level_nxt_c)
  );

  // Next-state and datapath decisions for the command FSM.
  always_comb begin
    state_d = state_q;
    ph_d    = ph_q;
    wcnt_d  = wcnt_q;
    bus_d   = bus_q;
    err_d   = err_op;
    wd_d    = writes_done;
    pop_c   = 1'b0;

    if (flush) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (!fifo_empty) begin
            pop_c = 1'b1;
            case (head_op)
              OP_WRITE: begin
                state_d     = ST_SETUP;
                ph_d        = '0;
                bus_d.voice = head_arg[VOICE_LSB +: VOICE_W];
                bus_d.addr  = head_arg[ADDR_LSB +: ADDR_W];
                bus_d.data  = head_arg[DATA_W-1:0];
              end
              OP_WAIT: begin
                if (head_arg != '0) begin
                  state_d = ST_WAIT;
                  wcnt_d  = head_arg;
                end
              end
              OP_SYNC: state_d = ST_SYNC;
              default: err_d = 1'b1;
            endcase
          end
        end
        ST_SETUP: begin
          if (ph_q == PH_W'(SETUP_CYC - 1)) begin
            state_d = ST_STROBE;
            ph_d    = '0;
          end else begin
            ph_d = ph_q + PH_W'(1);
          end
        end
        ST_STROBE: begin
          if (ph_q == PH_W'(STROBE_CYC - 1)) begin
            state_d = ST_HOLD;
            ph_d    = '0;
          end else begin
            ph_d = ph_q + PH_W'(1);
          end
        end
        ST_HOLD: begin
          if (ph_q == PH_W'(HOLD_CYC - 1)) begin
            state_d = ST_IDLE;
            ph_d    = '0;
            wd_d    = writes_done + CNT_W'(1);
          end else begin
            ph_d = ph_q + PH_W'(1);
          end
        end
        ST_WAIT: begin
          wcnt_d = wcnt_q - WAIT_W'(1);
          if (wcnt_q == WAIT_W'(1)) state_d = ST_IDLE;
        end
        ST_SYNC: begin
          if (sync_in) state_d = ST_IDLE;
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // State, counters and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      ph_q        <= '0;
      wcnt_q      <= '0;
      bus_q       <= '0;
      bus_we      <= 1'b0;
      busy        <= 1'b0;
      err_op      <= 1'b0;
      writes_done <= '0;
    end else begin
      state_q     <= state_d;
      ph_q        <= ph_d;
      wcnt_q      <= wcnt_d;
      bus_q       <= bus_d;
      bus_we      <= (state_d == ST_STROBE);
      busy        <= (state_d != ST_IDLE) || (level_nxt_c != '0);
      err_op      <= err_d;
      writes_done <= wd_d;
    end
  end

endmodule
